// File: rtl/ltssm_detect_polling_ctrl.sv
// LTSSM Detect/Polling sequencer driving the shared interval timer.
// Define LTSSM_FAST_SIM_EN to force every timed state onto the 2ms interval code.
module ltssm_detect_polling_ctrl #(
  parameter int TX_TS_MIN  = 1024,
  parameter int RX_TS_MIN  = 8,
  parameter int TX_TS2_MIN = 16
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       ElecIdleExit,
  input  logic       RxDetectDone,
  input  logic       ReceiverDetected,
  input  logic       RxOSValid,
  input  logic [1:0] RxOSType,
  input  logic       TxOSSent,
  input  logic       LinkDownReq,
  input  logic       TimeOut,
  output logic       TimerStart,
  output logic       TimerEnable,
  output logic [2:0] TimerIntervalCode,
  output logic       TxDetectRx,
  output logic       TxSendTS1,
  output logic       TxSendTS2,
  output logic [2:0] LtssmState,
  output logic       PollingComplete
);

  // Handshakes are level/pulse sampled at posedge Pclk; there is no back-pressure,
  // every *Valid/*Sent/*Done pulse is consumed in the cycle it is high.
  typedef enum logic [2:0] {
    DQUIET  = 3'd0,
    DACTIVE = 3'd1,
    PACTIVE = 3'd2,
    PCONFIG = 3'd3,
    CFG     = 3'd4
  } state_t;

  localparam logic [10:0] TX_MAX  = 11'(TX_TS_MIN);
  localparam logic [10:0] RX_MAX  = 11'(RX_TS_MIN);
  localparam logic [10:0] TX2_MAX = 11'(TX_TS2_MIN);

  state_t      state, next_state;
  logic [10:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic        seen_ts2, seen_ts2_n;
  logic        to_eff, is_ts, is_ts2, entering;

  logic       start_n, enable_n, detect_n, ts1_n, ts2_n, done_n;
  logic [2:0] code_n;

  assign LtssmState = state;
  assign to_eff     = TimeOut && !TimerStart;
  assign is_ts      = RxOSValid && (RxOSType == 2'b01 || RxOSType == 2'b10);
  assign is_ts2     = RxOSValid && (RxOSType == 2'b10);

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state             <= DQUIET;
      tx_cnt            <= '0;
      rx_cnt            <= '0;
      seen_ts2          <= 1'b0;
      TimerStart        <= 1'b1;
      TimerEnable       <= 1'b0;
      TimerIntervalCode <= 3'b001;
      TxDetectRx        <= 1'b0;
      TxSendTS1         <= 1'b0;
      TxSendTS2         <= 1'b0;
      PollingComplete   <= 1'b0;
    end else begin
      state             <= next_state;
      tx_cnt            <= tx_cnt_n;
      rx_cnt            <= rx_cnt_n;
      seen_ts2          <= seen_ts2_n;
      TimerStart        <= start_n;
      TimerEnable       <= enable_n;
      TimerIntervalCode <= code_n;
      TxDetectRx        <= detect_n;
      TxSendTS1         <= ts1_n;
      TxSendTS2         <= ts2_n;
      PollingComplete   <= done_n;
    end
  end

  // Counter next values include this cycle's events so exit decisions see them.
  always_comb begin
    next_state = state;
    tx_cnt_n   = tx_cnt;
    rx_cnt_n   = rx_cnt;
    seen_ts2_n = seen_ts2;
    unique case (state)
      DQUIET: begin
        if (to_eff || ElecIdleExit) next_state = DACTIVE;
      end
      DACTIVE: begin
        if (RxDetectDone) next_state = ReceiverDetected ? PACTIVE : DQUIET;
        else if (to_eff)  next_state = DQUIET;
      end
      PACTIVE: begin
        if (TxOSSent && tx_cnt != TX_MAX) tx_cnt_n = tx_cnt + 11'd1;
        if (RxOSValid) begin
          if (!is_ts)                rx_cnt_n = '0;
          else if (rx_cnt != RX_MAX) rx_cnt_n = rx_cnt + 11'd1;
        end
        if (tx_cnt_n == TX_MAX && rx_cnt_n == RX_MAX) next_state = PCONFIG;
        else if (to_eff)                              next_state = DQUIET;
      end
      PCONFIG: begin
        if (RxOSValid) begin
          if (!is_ts2)               rx_cnt_n = '0;
          else if (rx_cnt != RX_MAX) rx_cnt_n = rx_cnt + 11'd1;
        end
        if (is_ts2) seen_ts2_n = 1'b1;
        if (TxOSSent && seen_ts2 && tx_cnt != TX2_MAX) tx_cnt_n = tx_cnt + 11'd1;
        if (tx_cnt_n == TX2_MAX && rx_cnt_n == RX_MAX) next_state = CFG;
        else if (to_eff)                               next_state = DQUIET;
      end
      CFG: begin
        if (LinkDownReq) next_state = DQUIET;
      end
      default: next_state = DQUIET;
    endcase
    if (next_state != state) begin
      tx_cnt_n   = '0;
      rx_cnt_n   = '0;
      seen_ts2_n = 1'b0;
    end
  end

  always_comb begin
    entering = (next_state != state);
    start_n  = entering && (next_state != CFG);
    enable_n = (next_state != CFG);
    detect_n = entering && (next_state == DACTIVE);
    ts1_n    = (next_state == PACTIVE);
    ts2_n    = (next_state == PCONFIG);
    done_n   = (next_state == CFG);
`ifdef LTSSM_FAST_SIM_EN
    code_n   = 3'b100;
`else
    unique case (next_state)
      PACTIVE: code_n = 3'b010;
      PCONFIG: code_n = 3'b011;
      default: code_n = 3'b001;
    endcase
`endif
  end

endmodule

// File: tb/tb_ltssm_detect_polling_ctrl.sv
// Directed bench for ltssm_detect_polling_ctrl: detect loop, full training, count and timeout edges.
module tb_ltssm_detect_polling_ctrl;

  logic       Pclk = 1'b0;
  logic       Reset = 1'b0;
  logic       ElecIdleExit = 1'b0, RxDetectDone = 1'b0, ReceiverDetected = 1'b0;
  logic       RxOSValid = 1'b0, TxOSSent = 1'b0, LinkDownReq = 1'b0, TimeOut = 1'b0;
  logic [1:0] RxOSType = 2'b00;
  logic       TimerStart, TimerEnable, TxDetectRx, TxSendTS1, TxSendTS2, PollingComplete;
  logic [2:0] TimerIntervalCode, LtssmState;

  int checks = 0;
  int failures = 0;

  ltssm_detect_polling_ctrl dut (
    .Pclk(Pclk), .Reset(Reset), .ElecIdleExit(ElecIdleExit), .RxDetectDone(RxDetectDone),
    .ReceiverDetected(ReceiverDetected), .RxOSValid(RxOSValid), .RxOSType(RxOSType),
    .TxOSSent(TxOSSent), .LinkDownReq(LinkDownReq), .TimeOut(TimeOut),
    .TimerStart(TimerStart), .TimerEnable(TimerEnable), .TimerIntervalCode(TimerIntervalCode),
    .TxDetectRx(TxDetectRx), .TxSendTS1(TxSendTS1), .TxSendTS2(TxSendTS2),
    .LtssmState(LtssmState), .PollingComplete(PollingComplete)
  );

  always #5 Pclk = ~Pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  function automatic logic [2:0] exp_code(input logic [2:0] st);
`ifdef LTSSM_FAST_SIM_EN
    return 3'b100;
`else
    if (st == 3'd2) return 3'b010;
    if (st == 3'd3) return 3'b011;
    return 3'b001;
`endif
  endfunction

  task automatic clear_inputs();
    ElecIdleExit = 0; RxDetectDone = 0; ReceiverDetected = 0;
    RxOSValid = 0; RxOSType = 2'b00; TxOSSent = 0; LinkDownReq = 0; TimeOut = 0;
  endtask

  task automatic goto_pactive(input string tag);
    ElecIdleExit = 1; tick(); ElecIdleExit = 0;
    check_val({tag, "_dactive"}, LtssmState, 3'd1);
    RxDetectDone = 1; ReceiverDetected = 1; tick(); clear_inputs();
    check_val({tag, "_pactive"}, LtssmState, 3'd2);
    check_val({tag, "_pa_code"}, TimerIntervalCode, exp_code(3'd2));
    check_val({tag, "_pa_ts1"}, TxSendTS1, 1'b1);
  endtask

  initial begin
    // Reset held for three cycles
    clear_inputs();
    Reset = 0;
    repeat (3) tick();
    check_val("rst_state", LtssmState, 3'd0);
    check_val("rst_code", TimerIntervalCode, 3'b001);
    check_val("rst_start", TimerStart, 1'b1);
    check_val("rst_enable", TimerEnable, 1'b0);
    check_val("rst_tx", {TxDetectRx, TxSendTS1, TxSendTS2, PollingComplete}, 4'b0000);
    Reset = 1;
    tick();
    check_val("rel_start_drop", TimerStart, 1'b0);
    check_val("rel_enable", TimerEnable, 1'b1);
    repeat (3) tick();
    check_val("quiet_hold", LtssmState, 3'd0);
    check_val("quiet_code", TimerIntervalCode, exp_code(3'd0));

    // Detect loop without receiver
    TimeOut = 1; tick(); TimeOut = 0;
    check_val("to_dactive", LtssmState, 3'd1);
    check_val("detect_pulse", TxDetectRx, 1'b1);
    check_val("dactive_start", TimerStart, 1'b1);
    tick();
    check_val("detect_once", TxDetectRx, 1'b0);
    RxDetectDone = 1; ReceiverDetected = 0; tick(); clear_inputs();
    check_val("norx_dquiet", LtssmState, 3'd0);
    check_val("norx_start", TimerStart, 1'b1);

    // Full training to CFG
    goto_pactive("train");
    for (int i = 0; i < 1024; i++) begin
      TxOSSent = 1; RxOSValid = (i < 8); RxOSType = 2'b01;
      tick();
      if (i == 1022) check_val("pa_not_yet", LtssmState, 3'd2);
    end
    clear_inputs();
    check_val("to_pconfig", LtssmState, 3'd3);
    check_val("pc_code", TimerIntervalCode, exp_code(3'd3));
    check_val("pc_ts", {TxSendTS1, TxSendTS2}, 2'b01);
    check_val("pc_start", TimerStart, 1'b1);
    for (int j = 0; j < 17; j++) begin
      RxOSValid = (j < 8); RxOSType = 2'b10; TxOSSent = (j >= 1);
      tick();
      if (j == 15) check_val("pc_not_yet", LtssmState, 3'd3);
    end
    clear_inputs();
    check_val("to_cfg", LtssmState, 3'd4);
    check_val("cfg_done", PollingComplete, 1'b1);
    check_val("cfg_timer", {TimerStart, TimerEnable}, 2'b00);
    check_val("cfg_tx", {TxDetectRx, TxSendTS1, TxSendTS2}, 3'b000);
    tick();
    check_val("cfg_hold", LtssmState, 3'd4);
    LinkDownReq = 1; tick(); clear_inputs();
    check_val("linkdown", LtssmState, 3'd0);
    check_val("linkdown_start", TimerStart, 1'b1);
    check_val("linkdown_done", PollingComplete, 1'b0);

    // Broken TS1 run keeps PACTIVE, then timeout
    goto_pactive("brk");
    for (int i = 0; i < 1024; i++) begin
      TxOSSent = 1;
      RxOSValid = (i < 15);
      RxOSType = (i == 7) ? 2'b00 : 2'b01;
      tick();
    end
    clear_inputs();
    check_val("brk_stay", LtssmState, 3'd2);
    TimeOut = 1; tick();
    check_val("brk_timeout", LtssmState, 3'd0);
    tick();
    check_val("to_ignored_on_start", LtssmState, 3'd0);
    TimeOut = 0; tick();
    check_val("brk_quiet", LtssmState, 3'd0);

    // Completing TS1 and TimeOut in the same cycle
    goto_pactive("race");
    for (int i = 0; i < 1024; i++) begin
      TxOSSent = 1; RxOSValid = (i < 7); RxOSType = 2'b01;
      tick();
    end
    clear_inputs();
    check_val("race_pre", LtssmState, 3'd2);
    RxOSValid = 1; RxOSType = 2'b01; TimeOut = 1; tick(); clear_inputs();
    check_val("race_win", LtssmState, 3'd3);

    // Reset in the middle of PCONFIG
    RxOSValid = 1; RxOSType = 2'b10; tick(); clear_inputs(); tick();
    check_val("mid_pc", LtssmState, 3'd3);
    check_val("mid_pc_code", TimerIntervalCode, exp_code(3'd3));
    Reset = 0; tick();
    check_val("mid_rst_state", LtssmState, 3'd0);
    check_val("mid_rst_tx", {TxDetectRx, TxSendTS1, TxSendTS2}, 3'b000);
    check_val("mid_rst_timer", {TimerStart, TimerEnable, TimerIntervalCode}, 5'b10001);
    Reset = 1; tick();
    check_val("post_rst_code", TimerIntervalCode, exp_code(3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
